// File: rtl/csr_except_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, exception codes,
// status/enable/pending bit positions and the per-CSR writable-bit masks.
package csr_except_pkg;

  localparam int REG_BUS = 32;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam logic [REG_BUS-1:0] EXC_NONE      = 32'h0000_0000;
  localparam logic [REG_BUS-1:0] EXC_ILLEGAL   = 32'h0000_0002;
  localparam logic [REG_BUS-1:0] EXC_EBREAK    = 32'h0000_0003;
  localparam logic [REG_BUS-1:0] EXC_MRET      = 32'h0000_000a;
  localparam logic [REG_BUS-1:0] EXC_ECALL     = 32'h0000_000b;
  localparam logic [REG_BUS-1:0] EXC_TIMER_IRQ = 32'h8000_0007;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MTIP_BIT     = 7;

  localparam logic [REG_BUS-1:0] ALIGN4_MASK  = 32'hFFFF_FFFC;
  localparam logic [REG_BUS-1:0] MSTATUS_MASK = 32'h0000_0088;
  localparam logic [REG_BUS-1:0] MIE_MASK     = 32'h0000_0080;

  typedef enum logic [1:0] {
    TRAP_NONE,
    TRAP_ENTER,
    TRAP_MRET
  } trap_kind_e;

  // Bits a software write can actually store; read-only and unimplemented CSRs give 0.
  function automatic logic [REG_BUS-1:0] csr_wmask(input logic [11:0] addr);
    logic [REG_BUS-1:0] mask;
    case (addr)
      CSR_MSTATUS:  mask = MSTATUS_MASK;
      CSR_MIE:      mask = MIE_MASK;
      CSR_MTVEC:    mask = ALIGN4_MASK;
      CSR_MEPC:     mask = ALIGN4_MASK;
      CSR_MSCRATCH: mask = '1;
      CSR_MCAUSE:   mask = '1;
      CSR_MCYCLE:   mask = '1;
      CSR_MCYCLEH:  mask = '1;
      default:      mask = '0;
    endcase
    return mask;
  endfunction

  function automatic trap_kind_e classify_trap(input logic [REG_BUS-1:0] code);
    trap_kind_e kind;
    if (code == EXC_MRET)
      kind = TRAP_MRET;
    else if (code != EXC_NONE)
      kind = TRAP_ENTER;
    else
      kind = TRAP_NONE;
    return kind;
  endfunction

endpackage

// File: rtl/csr_cycle_counter.sv
// Free-running 64-bit cycle counter; a write to either half replaces that half and
// suppresses the increment for that cycle.
module csr_cycle_counter
  import csr_except_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we_lo,
  input  logic               i_we_hi,
  input  logic [REG_BUS-1:0] i_wdata,
  output logic [63:0]        o_count
);

  logic [63:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_we_lo || i_we_hi) begin
      if (i_we_lo) r_count[31:0]  <= i_wdata;
      if (i_we_hi) r_count[63:32] <= i_wdata;
    end else begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_except.sv
// Machine-mode CSR file beside MEM: qualifies the timer interrupt, reports the final
// trap code to the controller and commits mepc/mcause/mstatus on the following edge.
module csr_except
  import csr_except_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_BUS-1:0] excepttype_i,
  input  logic               inst_valid_i,
  input  logic [REG_BUS-1:0] current_inst_addr_i,
  input  logic               irq_timer_i,
  input  logic               we_i,
  input  logic [11:0]        waddr_i,
  input  logic [REG_BUS-1:0] wdata_i,
  input  logic [11:0]        raddr_i,
  output logic [REG_BUS-1:0] rdata_o,
  output logic [REG_BUS-1:0] excepttype_o,
  output logic [REG_BUS-1:0] csr_mepc_o,
  output logic [REG_BUS-1:0] csr_mtvec_o
);

  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic               r_mie_mtie;
  logic               r_mip_mtip;
  logic [REG_BUS-1:0] r_mtvec;
  logic [REG_BUS-1:0] r_mscratch;
  logic [REG_BUS-1:0] r_mepc;
  logic [REG_BUS-1:0] r_mcause;

  logic               w_wr_mstatus;
  logic               w_wr_mie;
  logic               w_wr_mtvec;
  logic               w_wr_mscratch;
  logic               w_wr_mepc;
  logic               w_wr_mcause;
  logic               w_wr_mcycle;
  logic               w_wr_mcycleh;
  logic               w_irq_take;
  logic [REG_BUS-1:0] w_excepttype;
  trap_kind_e         w_trap_kind;
  logic [REG_BUS-1:0] w_mstatus;
  logic [REG_BUS-1:0] w_mie;
  logic [REG_BUS-1:0] w_mip;
  logic [63:0]        w_mcycle;
  logic [REG_BUS-1:0] w_rd_stored;
  logic               w_rd_bypass;

  assign w_wr_mstatus  = we_i && (waddr_i == CSR_MSTATUS);
  assign w_wr_mie      = we_i && (waddr_i == CSR_MIE);
  assign w_wr_mtvec    = we_i && (waddr_i == CSR_MTVEC);
  assign w_wr_mscratch = we_i && (waddr_i == CSR_MSCRATCH);
  assign w_wr_mepc     = we_i && (waddr_i == CSR_MEPC);
  assign w_wr_mcause   = we_i && (waddr_i == CSR_MCAUSE);
  assign w_wr_mcycle   = we_i && (waddr_i == CSR_MCYCLE);
  assign w_wr_mcycleh  = we_i && (waddr_i == CSR_MCYCLEH);

  // The gate uses registered MIE, so a same-cycle mstatus write cannot open it early.
  assign w_irq_take = (excepttype_i == EXC_NONE) && inst_valid_i &&
                      r_mstatus_mie && r_mie_mtie && r_mip_mtip;

  always_comb begin
    w_excepttype = EXC_NONE;
    if (rst)
      w_excepttype = EXC_NONE;
    else if (w_irq_take)
      w_excepttype = EXC_TIMER_IRQ;
    else if (inst_valid_i)
      w_excepttype = excepttype_i;
  end

  assign w_trap_kind  = classify_trap(w_excepttype);
  assign excepttype_o = w_excepttype;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mip_mtip     <= 1'b0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
    end else begin
      r_mip_mtip <= irq_timer_i;
      if (w_wr_mie)      r_mie_mtie <= wdata_i[MIE_MTIE_BIT];
      if (w_wr_mtvec)    r_mtvec    <= wdata_i & ALIGN4_MASK;
      if (w_wr_mscratch) r_mscratch <= wdata_i;

      case (w_trap_kind)
        TRAP_ENTER: begin
          r_mepc         <= current_inst_addr_i & ALIGN4_MASK;
          r_mcause       <= w_excepttype;
          r_mstatus_mpie <= r_mstatus_mie;
          r_mstatus_mie  <= 1'b0;
        end
        TRAP_MRET: begin
          r_mstatus_mie  <= r_mstatus_mpie;
          r_mstatus_mpie <= 1'b1;
          if (w_wr_mepc)   r_mepc   <= wdata_i & ALIGN4_MASK;
          if (w_wr_mcause) r_mcause <= wdata_i;
        end
        default: begin
          if (w_wr_mepc)   r_mepc   <= wdata_i & ALIGN4_MASK;
          if (w_wr_mcause) r_mcause <= wdata_i;
          if (w_wr_mstatus) begin
            r_mstatus_mie  <= wdata_i[MSTATUS_MIE_BIT];
            r_mstatus_mpie <= wdata_i[MSTATUS_MPIE_BIT];
          end
        end
      endcase
    end
  end

  csr_cycle_counter u_cycle (
    .clk     (clk),
    .rst     (rst),
    .i_we_lo (w_wr_mcycle),
    .i_we_hi (w_wr_mcycleh),
    .i_wdata (wdata_i),
    .o_count (w_mcycle)
  );

  always_comb begin
    w_mstatus                   = '0;
    w_mstatus[MSTATUS_MIE_BIT]  = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
    w_mie                       = '0;
    w_mie[MIE_MTIE_BIT]         = r_mie_mtie;
    w_mip                       = '0;
    w_mip[MIP_MTIP_BIT]         = r_mip_mtip;
  end

  always_comb begin
    w_rd_stored = '0;
    case (raddr_i)
      CSR_MSTATUS:  w_rd_stored = w_mstatus;
      CSR_MIE:      w_rd_stored = w_mie;
      CSR_MTVEC:    w_rd_stored = r_mtvec;
      CSR_MSCRATCH: w_rd_stored = r_mscratch;
      CSR_MEPC:     w_rd_stored = r_mepc;
      CSR_MCAUSE:   w_rd_stored = r_mcause;
      CSR_MIP:      w_rd_stored = w_mip;
      CSR_MCYCLE:   w_rd_stored = w_mcycle[31:0];
      CSR_MCYCLEH:  w_rd_stored = w_mcycle[63:32];
      default:      w_rd_stored = '0;
    endcase
  end

  // mip is read-only, so a write aimed at it must not show up on the read port.
  assign w_rd_bypass = we_i && (waddr_i == raddr_i) && (raddr_i != CSR_MIP);

  assign rdata_o     = rst ? '0 :
                       (w_rd_bypass ? (wdata_i & csr_wmask(raddr_i)) : w_rd_stored);
  assign csr_mepc_o  = rst ? '0 : (w_wr_mepc  ? (wdata_i & ALIGN4_MASK) : r_mepc);
  assign csr_mtvec_o = rst ? '0 : (w_wr_mtvec ? (wdata_i & ALIGN4_MASK) : r_mtvec);

endmodule

// File: tb/tb_csr_except.sv
// Directed bench for csr_except: a vector table for single-cycle CSR/trap behaviour and
// hand-written sequences for interrupt latency, bubbles, mret bypass, mcycle and reset.
module tb_csr_except;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] excepttype_i;
  logic        inst_valid_i;
  logic [31:0] current_inst_addr_i;
  logic        irq_timer_i;
  logic        we_i;
  logic [11:0] waddr_i;
  logic [31:0] wdata_i;
  logic [11:0] raddr_i;
  logic [31:0] rdata_o;
  logic [31:0] excepttype_o;
  logic [31:0] csr_mepc_o;
  logic [31:0] csr_mtvec_o;

  always #5 clk = ~clk;

  csr_except dut (
    .clk                 (clk),
    .rst                 (rst),
    .excepttype_i        (excepttype_i),
    .inst_valid_i        (inst_valid_i),
    .current_inst_addr_i (current_inst_addr_i),
    .irq_timer_i         (irq_timer_i),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .wdata_i             (wdata_i),
    .raddr_i             (raddr_i),
    .rdata_o             (rdata_o),
    .excepttype_o        (excepttype_o),
    .csr_mepc_o          (csr_mepc_o),
    .csr_mtvec_o         (csr_mtvec_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] exc;
    logic        vld;
    logic [31:0] pc;
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic [31:0] e_exc;
    logic [31:0] e_rd;
    logic [31:0] e_mepc;
    logic [31:0] e_mtvec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] exc, input logic vld, input logic [31:0] pc,
                              input logic we, input logic [11:0] wa, input logic [31:0] wd,
                              input logic [11:0] ra, input logic [31:0] e_exc,
                              input logic [31:0] e_rd, input logic [31:0] e_mepc,
                              input logic [31:0] e_mtvec);
    vec_t v;
    v.exc = exc; v.vld = vld; v.pc = pc; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra;
    v.e_exc = e_exc; v.e_rd = e_rd; v.e_mepc = e_mepc; v.e_mtvec = e_mtvec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] exc, input logic vld, input logic [31:0] pc,
                       input logic we, input logic [11:0] wa, input logic [31:0] wd,
                       input logic [11:0] ra);
    excepttype_i        = exc;
    inst_valid_i        = vld;
    current_inst_addr_i = pc;
    we_i                = we;
    waddr_i             = wa;
    wdata_i             = wd;
    raddr_i             = ra;
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] e_exc, input logic [31:0] e_rd,
                            input logic [31:0] e_mepc, input logic [31:0] e_mtvec);
    check({tag, ".exc"},   excepttype_o, e_exc);
    check({tag, ".rdata"}, rdata_o,      e_rd);
    check({tag, ".mepc"},  csr_mepc_o,   e_mepc);
    check({tag, ".mtvec"}, csr_mtvec_o,  e_mtvec);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // exc, vld, pc, we, waddr, wdata, raddr | exp exc, rdata, mepc_o, mtvec_o
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h300, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h304, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h305, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h340, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h341, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h342, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h344, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h7C0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 12'h305, 32'h0000_0103, 12'h305, 0, 32'h100, 0, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h305, 0, 32'h100, 0, 32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 12'h340, 32'hDEAD_BEEF, 12'h340, 0, 32'hDEAD_BEEF, 0, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h340, 0, 32'hDEAD_BEEF, 0, 32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 12'h7C0, 32'h0000_1234, 12'h7C0, 0, 0, 0, 32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 12'h300, 32'hFFFF_FFFF, 12'h300, 0, 32'h88, 0, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h300, 0, 32'h88, 0, 32'h100));
    vecs.push_back(mk(32'hb, 1, 32'h80, 0, 12'h000, 0, 12'h300, 32'hb, 32'h88, 0, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h341, 0, 32'h80, 32'h80, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h342, 0, 32'hb, 32'h80, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h300, 0, 32'h80, 32'h80, 32'h100));
    vecs.push_back(mk(32'h2, 0, 32'h84, 0, 12'h000, 0, 12'h342, 0, 32'hb, 32'h80, 32'h100));
    vecs.push_back(mk(32'h2, 1, 32'h84, 0, 12'h000, 0, 12'h300, 32'h2, 32'h80, 32'h80, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h300, 0, 0, 32'h84, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h342, 0, 32'h2, 32'h84, 32'h100));
    vecs.push_back(mk(32'ha, 1, 32'h88, 0, 12'h000, 0, 12'h300, 32'ha, 0, 32'h84, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h300, 0, 32'h80, 32'h84, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h342, 0, 32'h2, 32'h84, 32'h100));
    vecs.push_back(mk(32'h3, 1, 32'h93, 1, 12'h341, 32'h555, 12'h341, 32'h3, 32'h554, 32'h554, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h341, 0, 32'h90, 32'h90, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h342, 0, 32'h3, 32'h90, 32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 12'h341, 32'h403, 12'h341, 0, 32'h400, 32'h400, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h300, 0, 0, 32'h400, 32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 12'h344, 32'hFFFF_FFFF, 12'h344, 0, 0, 32'h400, 32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 12'h304, 32'hFFFF_FFFF, 12'h304, 0, 32'h80, 32'h400, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 12'h000, 0, 12'h304, 0, 32'h80, 32'h400, 32'h100));

    rst = 1'b1;
    irq_timer_i = 1'b0;
    drive(32'hb, 1, 32'h600, 1, 12'h341, 32'h123, 12'h341);
    expect_out("rst_hold", 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].exc, vecs[i].vld, vecs[i].pc, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra);
      expect_out($sformatf("vec%0d", i), vecs[i].e_exc, vecs[i].e_rd, vecs[i].e_mepc, vecs[i].e_mtvec);
      tick();
    end

    // timer interrupt with MIE=1: taken the cycle after MTIP registers
    drive(0, 0, 0, 1, 12'h300, 32'h8, 12'h300);
    expect_out("irq_en", 0, 32'h08, 32'h400, 32'h100);
    tick();
    irq_timer_i = 1'b1;
    drive(0, 1, 32'h200, 0, 12'h000, 0, 12'h344);
    expect_out("irq_n", 0, 0, 32'h400, 32'h100);
    tick();
    irq_timer_i = 1'b0;
    drive(0, 1, 32'h200, 0, 12'h000, 0, 12'h344);
    expect_out("irq_n1", 32'h8000_0007, 32'h80, 32'h400, 32'h100);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'h342);
    expect_out("irq_commit", 0, 32'h8000_0007, 32'h200, 32'h100);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'h300);
    expect_out("irq_mstatus", 0, 32'h80, 32'h200, 32'h100);
    tick();

    // MIE=0: a held timer level is never taken
    irq_timer_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h240, 0, 12'h000, 0, 12'h344);
      expect_out($sformatf("mie0_%0d", k), 0, (k == 0) ? 32'h0 : 32'h80, 32'h200, 32'h100);
      tick();
    end

    // MIE enabled by a same-cycle write, then three bubbles defer the interrupt
    drive(0, 1, 32'h300, 1, 12'h300, 32'h8, 12'h300);
    expect_out("late_en", 0, 32'h08, 32'h200, 32'h100);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 32'h304, 0, 12'h000, 0, 12'h344);
      expect_out($sformatf("bubble%0d", k), 0, 32'h80, 32'h200, 32'h100);
      tick();
    end
    drive(0, 1, 32'h310, 0, 12'h000, 0, 12'h300);
    expect_out("bubble_take", 32'h8000_0007, 32'h08, 32'h200, 32'h100);
    tick();
    irq_timer_i = 1'b0;
    drive(0, 0, 0, 0, 12'h000, 0, 12'h341);
    expect_out("bubble_mepc", 0, 32'h310, 32'h310, 32'h100);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'h300);
    expect_out("bubble_mstatus", 0, 32'h80, 32'h310, 32'h100);
    tick();

    // mret with a same-cycle mepc write
    drive(32'ha, 1, 32'h320, 1, 12'h341, 32'h400, 12'h341);
    expect_out("mret_wr", 32'ha, 32'h400, 32'h400, 32'h100);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'h300);
    expect_out("mret_after", 0, 32'h88, 32'h400, 32'h100);
    tick();

    // mcycle per-half write, low-half carry and full 64-bit wrap
    drive(0, 0, 0, 1, 12'hB80, 32'h5, 12'hB80);
    check("cyc_wr_hi", rdata_o, 32'h5);
    tick();
    drive(0, 0, 0, 1, 12'hB00, 32'hFFFF_FFFF, 12'hB00);
    check("cyc_wr_lo", rdata_o, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'hB00);
    check("cyc_hold", rdata_o, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'hB80);
    check("cyc_carry_hi", rdata_o, 32'h6);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'hB00);
    check("cyc_carry_lo", rdata_o, 32'h1);
    tick();
    drive(0, 0, 0, 1, 12'hB80, 32'hFFFF_FFFF, 12'hB80);
    check("wrap_wr_hi", rdata_o, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 0, 1, 12'hB00, 32'hFFFF_FFFF, 12'hB80);
    check("wrap_hi_kept", rdata_o, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'hB00);
    check("wrap_lo_max", rdata_o, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'hB80);
    check("wrap_hi0", rdata_o, 32'h0);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'hB00);
    check("wrap_lo1", rdata_o, 32'h1);
    tick();

    // reset asserted alongside an ecall: nothing commits
    rst = 1'b1;
    drive(32'hb, 1, 32'h600, 0, 12'h000, 0, 12'h305);
    expect_out("rst_trap", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 12'h000, 0, 12'hB00);
    expect_out("rst_mcycle", 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'h341);
    expect_out("rst_mepc", 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'h342);
    expect_out("rst_mcause", 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'h300);
    expect_out("rst_mstatus", 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 12'h000, 0, 12'h304);
    expect_out("rst_mie", 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
